// File: rtl/bids22_cmd_sequencer.sv
// Command sequencer for the bids22 auction core: a command FIFO replayed onto the
// core's C_op/C_data/C_start port, paced by core_ready, with round windows and error capture.
module bids22_cmd_sequencer #(
    parameter int DATAWIDTH   = 32,
    parameter int OPWIDTH     = 4,
    parameter int ERRWIDTH    = 4,
    parameter int DEPTH       = 8,
    parameter int HALT_ON_ERR = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [OPWIDTH-1:0]         cmd_op,
    input  logic [DATAWIDTH-1:0]       cmd_data,
    input  logic                       cmd_start,
    output logic [OPWIDTH-1:0]         C_op,
    output logic [DATAWIDTH-1:0]       C_data,
    output logic                       C_start,
    input  logic                       core_ready,
    input  logic [ERRWIDTH-1:0]        core_err,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy,
    output logic                       err_sticky,
    output logic [ERRWIDTH-1:0]        err_code,
    output logic                       halted,
    input  logic                       halt_clear
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic                 start;
        logic [DATAWIDTH-1:0] data;
        logic [OPWIDTH-1:0]   op;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ROUND, S_DRAIN} state_e;

    cmd_t                 mem_q [DEPTH];
    cmd_t                 head;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] cnt_q, cnt_d;
    logic [OPWIDTH-1:0]   c_op_q, c_op_d;
    logic [DATAWIDTH-1:0] c_data_q, c_data_d;
    logic                 c_start_q, c_start_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [ERRWIDTH-1:0]  err_code_q, err_code_d;
    logic                 halted_q, halted_d;
    logic                 push, pop, err_hit;

    assign head    = mem_q[rd_ptr_q];
    assign push    = cmd_valid && cmd_ready;
    assign pop     = (state_q == S_IDLE) && (count_q != '0) && core_ready && !halted_q;
    assign err_hit = (state_q == S_ISSUE) && (core_err != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: the storage array carries no reset; only pointers and count are reset,
    // so the array maps onto plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{start: cmd_start, data: cmd_data, op: cmd_op};
        end
    end

    // Next-state logic; cnt_q counts the round window and then the drain floor.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head.start) begin
                        state_d = S_ROUND;
                        cnt_d   = (head.data == '0) ? DATAWIDTH'(1) : head.data;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_IDLE;
            S_ROUND: begin
                if (cnt_q <= DATAWIDTH'(1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = DATAWIDTH'(2);
                end else begin
                    cnt_d = cnt_q - DATAWIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q > DATAWIDTH'(1)) begin
                    cnt_d = cnt_q - DATAWIDTH'(1);
                end else if (core_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: core-facing outputs are decoded from state_d and registered, so they
    // change on the same edge that enters the state instead of one cycle later.
    always_comb begin
        c_op_d    = '0;
        c_data_d  = '0;
        c_start_d = 1'b0;
        if (state_d == S_ISSUE) begin
            c_op_d   = head.op;
            c_data_d = head.data;
        end
        if (state_d == S_ROUND) begin
            c_start_d = 1'b1;
        end
    end

    always_comb begin
        err_sticky_d = err_sticky_q;
        err_code_d   = err_code_q;
        halted_d     = halted_q;
        if (halt_clear) begin
            err_sticky_d = 1'b0;
            err_code_d   = '0;
            halted_d     = 1'b0;
        end else if (err_hit) begin
            if (!err_sticky_q) begin
                err_sticky_d = 1'b1;
                err_code_d   = core_err;
            end
            if (HALT_ON_ERR != 0) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            c_op_q       <= '0;
            c_data_q     <= '0;
            c_start_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_code_q   <= '0;
            halted_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            c_op_q       <= c_op_d;
            c_data_q     <= c_data_d;
            c_start_q    <= c_start_d;
            err_sticky_q <= err_sticky_d;
            err_code_q   <= err_code_d;
            halted_q     <= halted_d;
        end
    end

    assign cmd_ready  = (count_q != CW'(DEPTH));
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign C_op       = c_op_q;
    assign C_data     = c_data_q;
    assign C_start    = c_start_q;
    assign err_sticky = err_sticky_q;
    assign err_code   = err_code_q;
    assign halted     = halted_q;

endmodule

// File: doc/bids22_cmd_sequencer.md
Name: bids22_cmd_sequencer

Overview:
- Upstream command stage for the bids22 auction core.
- Buffers host/testbench commands in a FIFO and replays them onto the core's C_op/C_data/C_start control inputs with correct timing, one command at a time.
- Paces commands with the core's ready signal, generates round windows of programmed length and captures core error codes.
- Sits between the host command source and the auction core's control port.

Parameters:
- DATAWIDTH, 32, width of command data and C_data.
- OPWIDTH, 4, width of opcode and C_op. Opcodes are opaque to this block except 0 = NO_OP.
- ERRWIDTH, 4, width of core error code. 0 = NOERROR.
- DEPTH, 8, command FIFO entries. Power of two, at least 2.
- HALT_ON_ERR, 1, 1 = stop issuing after a core error until halt_clear.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host offers a command
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_op  in  OPWIDTH  opcode to issue
- cmd_data  in  DATAWIDTH  operand, or round length when cmd_start=1
- cmd_start  in  1  command is a round: drive C_start for cmd_data cycles
- C_op  out  OPWIDTH  to core
- C_data  out  DATAWIDTH  to core
- C_start  out  1  to core
- core_ready  in  1  core ready
- core_err  in  ERRWIDTH  core error output
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- busy  out  1  state != IDLE or FIFO non-empty
- err_sticky  out  1  a core error has been seen since reset/halt_clear
- err_code  out  ERRWIDTH  first error captured
- halted  out  1  issuing suspended
- halt_clear  in  1  one-cycle pulse; clears halted, err_sticky, err_code

Behaviour:
- Reset (async, any state): FIFO emptied, state IDLE, C_op=0, C_data=0, C_start=0, err_sticky=0, err_code=0, halted=0, fifo_count=0, cmd_ready=1, busy=0. An in-flight round is abandoned; C_start drops immediately.
- FIFO write: a command is pushed when cmd_valid && cmd_ready. No bypass: an entry is poppable the cycle after it is pushed.
- Simultaneous push and pop while full: the push is refused because cmd_ready=0 that cycle.
- Pointers wrap modulo DEPTH.
- All core-facing outputs are registered. Defaults are C_op=0, C_data=0, C_start=0 in every state unless stated below.
- State IDLE:
  - Pops the head when FIFO non-empty && core_ready && !halted.
  - If the head has cmd_start=0, next state is ISSUE.
  - If the head has cmd_start=1, next state is ROUND with a down-counter loaded with max(cmd_data,1).
- State ISSUE (exactly 1 cycle):
  - C_op and C_data = popped command.
  - core_err is sampled this cycle. If non-zero and err_sticky=0: err_code<=core_err, err_sticky<=1.
  - If non-zero and HALT_ON_ERR=1: halted<=1.
  - Next state is IDLE.
- State ROUND:
  - C_start=1 and C_op=0. The counter decrements each cycle.
  - C_start is high for exactly N cycles, N = max(cmd_data,1).
  - When the counter reaches 1, next state is DRAIN.
  - core_err is ignored during ROUND; the core's duplicate-bid error is not a command error.
- State DRAIN:
  - C_start=0. Waits at least 2 cycles, covering the core's round-over and ready-next phases, then continues until core_ready=1.
  - Next state is IDLE.
- Throughput: with core_ready held high, one non-round command issues every 2 cycles (IDLE pop, ISSUE drive).
- halt_clear has priority over a same-cycle error capture, so the clear wins.
- busy=0 only when the FIFO is empty and the state is IDLE.

Test Plan:
- Reset, then push op=4 data=0x64 → C_op=4, C_data=0x64 for exactly 1 cycle, 2 cycles after the push cycle. C_start=0. fifo_count returns to 0.
- Push DEPTH+1 commands with core_ready=0 → cmd_ready=0 after the 8th push, 9th push refused, fifo_count=8. Raise core_ready → 8 commands issue in order, spaced 2 cycles apart.
- Push round cmd_start=1 data=5 → C_start high exactly 5 consecutive cycles. Hold core_ready=0 for 3 cycles after C_start falls → next command not issued until core_ready=1. A round with data=0 gives a 1-cycle C_start.
- Issue a command while core_err=3 in the ISSUE cycle, HALT_ON_ERR=1 → err_sticky=1, err_code=3, halted=1, remaining queued commands held. Pulse halt_clear → flags cleared, issuing resumes.
- Assert reset_n=0 mid-round (cycle 2 of 5) → C_start=0 immediately, fifo_count=0, state IDLE. After release, no stale command is issued.
- Push and pop in the same cycle at fifo_count=4 → count stays 4. Exercise pointer wrap over 3×DEPTH commands with no loss or reordering.
